// File: rtl/panel_loader.sv
// Front-panel loader: deposits an image into a PDP-8 through the panel switches and
// the Load PC / Deposit buttons, starts the program, then waits for the CPU to halt.
module panel_loader #(
  parameter int HOLD = 10
) (
  input  logic        clk,
  input  logic        btnCpuReset,
  input  logic        start,
  input  logic [12:0] word_count,
  input  logic [11:0] start_pc,
  output logic        img_req,
  output logic [11:0] img_addr,
  input  logic        img_valid,
  input  logic [11:0] img_data,
  output logic [12:0] sw,
  output logic        load_pc,
  output logic        deposit,
  input  logic        run_led,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0]  HOLD_M1   = 8'(HOLD - 1);
  localparam logic [12:0] MAX_WORDS = 13'd4096;

  typedef enum logic [3:0] {
    IDLE,
    PC0_SET,
    PC0_HI,
    PC0_LO,
    FETCH,
    DEP_SET,
    DEP_HI,
    DEP_LO,
    PC_SET,
    PC_HI,
    PC_LO,
    RUN,
    WAIT_HALT,
    DONE
  } state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic        run_q;
  logic [12:0] count_q;
  logic [11:0] pc_q;
  logic        hold_end;
  logic        last_word;

  assign hold_end  = (cnt == 8'd0);
  // img_addr doubles as the index of the word being deposited
  assign last_word = ({1'b0, img_addr} == (count_q - 13'd1));

  // Job parameters are plain data captured at start acceptance
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      count_q <= (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
      pc_q    <= start_pc;
    end
  end

  always_ff @(posedge clk or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      state    <= IDLE;
      sw       <= '0;
      load_pc  <= 1'b0;
      deposit  <= 1'b0;
      img_req  <= 1'b0;
      img_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      run_q    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cnt != 8'd0) cnt <= cnt - 8'd1;

      case (state)
        IDLE: begin
          if (start) begin
            state     <= PC0_SET;
            cnt       <= HOLD_M1;
            sw[11:0]  <= '0;
            img_addr  <= '0;
            busy      <= 1'b1;
          end
        end

        PC0_SET: begin
          if (hold_end) begin
            state   <= PC0_HI;
            cnt     <= HOLD_M1;
            load_pc <= 1'b1;
          end
        end

        PC0_HI: begin
          if (hold_end) begin
            state   <= PC0_LO;
            cnt     <= HOLD_M1;
            load_pc <= 1'b0;
          end
        end

        PC0_LO: begin
          if (hold_end) begin
            cnt <= HOLD_M1;
            if (count_q == 13'd0) begin
              state    <= PC_SET;
              sw[11:0] <= pc_q;
            end else begin
              state   <= FETCH;
              img_req <= 1'b1;
            end
          end
        end

        // Request stays up with a stable address until the source answers
        FETCH: begin
          if (img_valid) begin
            state    <= DEP_SET;
            cnt      <= HOLD_M1;
            img_req  <= 1'b0;
            sw[11:0] <= img_data;
          end
        end

        DEP_SET: begin
          if (hold_end) begin
            state   <= DEP_HI;
            cnt     <= HOLD_M1;
            deposit <= 1'b1;
          end
        end

        DEP_HI: begin
          if (hold_end) begin
            state   <= DEP_LO;
            cnt     <= HOLD_M1;
            deposit <= 1'b0;
          end
        end

        // 12-bit address wraps naturally after the 4096th word
        DEP_LO: begin
          if (hold_end) begin
            cnt      <= HOLD_M1;
            img_addr <= img_addr + 12'd1;
            if (last_word) begin
              state    <= PC_SET;
              sw[11:0] <= pc_q;
            end else begin
              state   <= FETCH;
              img_req <= 1'b1;
            end
          end
        end

        PC_SET: begin
          if (hold_end) begin
            state   <= PC_HI;
            cnt     <= HOLD_M1;
            load_pc <= 1'b1;
          end
        end

        PC_HI: begin
          if (hold_end) begin
            state   <= PC_LO;
            cnt     <= HOLD_M1;
            load_pc <= 1'b0;
          end
        end

        PC_LO: begin
          if (hold_end) begin
            state  <= RUN;
            cnt    <= HOLD_M1;
            sw[12] <= 1'b1;
          end
        end

        // Clearing the sample on entry means a LED already low never reads as a halt
        RUN: begin
          if (hold_end) begin
            state <= WAIT_HALT;
            run_q <= 1'b0;
          end
        end

        WAIT_HALT: begin
          run_q <= run_led;
          if (run_q && !run_led) begin
            state  <= DONE;
            done   <= 1'b1;
            sw[12] <= 1'b0;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_panel_loader.sv
// Bench for panel_loader: randomized image loads checked against a behavioural model of
// the panel pulse sequence, plus halt detection, reset abort and full-memory wrap.
module tb_panel_loader;
  localparam int H  = 10;
  localparam int H2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        btnCpuReset = 1'b0;
  logic        start = 1'b0, img_valid = 1'b0, run_led = 1'b0;
  logic [12:0] word_count = '0;
  logic [11:0] start_pc = '0, img_data = '0;
  logic        img_req, load_pc, deposit, busy, done;
  logic [11:0] img_addr;
  logic [12:0] sw;

  logic        start2 = 1'b0, img_valid2 = 1'b0, run_led2 = 1'b0;
  logic [12:0] word_count2 = '0;
  logic [11:0] start_pc2 = '0, img_data2 = '0;
  logic        img_req2, load_pc2, deposit2, busy2, done2;
  logic [11:0] img_addr2;
  logic [12:0] sw2;

  panel_loader #(.HOLD(H)) u_dut (
    .clk(clk), .btnCpuReset(btnCpuReset), .start(start), .word_count(word_count),
    .start_pc(start_pc), .img_req(img_req), .img_addr(img_addr), .img_valid(img_valid),
    .img_data(img_data), .sw(sw), .load_pc(load_pc), .deposit(deposit),
    .run_led(run_led), .busy(busy), .done(done)
  );

  panel_loader #(.HOLD(H2)) u_dut2 (
    .clk(clk), .btnCpuReset(btnCpuReset), .start(start2), .word_count(word_count2),
    .start_pc(start_pc2), .img_req(img_req2), .img_addr(img_addr2), .img_valid(img_valid2),
    .img_data(img_data2), .sw(sw2), .load_pc(load_pc2), .deposit(deposit2),
    .run_led(run_led2), .busy(busy2), .done(done2)
  );

  int passed = 0, total = 0;

  // Image source for the main instance: answers each request after a chosen delay
  logic [11:0] mem [0:4095];
  int fixed_dly = 0, cur_dly = 0, wait_k = 0;
  bit served = 1'b0;
  int dly_log[$];

  always @(negedge clk) begin
    if (img_req !== 1'b1) begin
      img_valid = 1'b0; served = 1'b0; wait_k = 0;
      cur_dly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 6));
    end else if (img_valid) begin
      img_valid = 1'b0;
    end else if (!served) begin
      if (wait_k == cur_dly) begin
        img_valid = 1'b1; img_data = mem[img_addr]; served = 1'b1; dly_log.push_back(wait_k);
      end else wait_k++;
    end
  end

  // Image source for the wrap instance: data is a fixed function of the address
  always @(negedge clk) begin
    if (img_req2 === 1'b1 && !img_valid2) begin
      img_valid2 = 1'b1; img_data2 = img_addr2 ^ 12'hA5A;
    end else img_valid2 = 1'b0;
  end

  // Observed panel activity of the main instance
  bit mon_en = 1'b0;
  logic prev_lp = 1'b0, prev_dep = 1'b0, prev_req = 1'b0;
  logic [11:0] prev_addr = '0;
  int lp_w = 0, dep_w = 0, overlap = 0, addr_moves = 0, req_rises = 0, done_cnt = 0;
  logic [11:0] lp_val[$], dep_val[$], dep_addr[$];
  int lp_wid[$], dep_wid[$];

  always @(negedge clk) begin
    if (mon_en) begin
      if (load_pc && deposit) overlap++;
      if (load_pc && !prev_lp) begin lp_val.push_back(sw[11:0]); lp_w = 0; end
      if (load_pc) lp_w++;
      if (!load_pc && prev_lp) lp_wid.push_back(lp_w);
      if (deposit && !prev_dep) begin dep_val.push_back(sw[11:0]); dep_addr.push_back(img_addr); dep_w = 0; end
      if (deposit) dep_w++;
      if (!deposit && prev_dep) dep_wid.push_back(dep_w);
      if (img_req && !prev_req) req_rises++;
      if (img_req && prev_req && img_addr !== prev_addr) addr_moves++;
      if (done) done_cnt++;
      prev_lp = load_pc; prev_dep = deposit; prev_req = img_req; prev_addr = img_addr;
    end
  end

  bit mon2_en = 1'b0;
  logic prev_dep2 = 1'b0, prev_lp2 = 1'b0;
  int dep2_cnt = 0, dep2_bad = 0, dep2_w = 0;
  logic [11:0] lp2_val[$], lp2_addr[$];

  always @(negedge clk) begin
    if (mon2_en) begin
      if (deposit2 && !prev_dep2) begin
        if (sw2[11:0] !== (img_addr2 ^ 12'hA5A) || img_addr2 !== 12'(dep2_cnt)) dep2_bad++;
        dep2_cnt++; dep2_w = 0;
      end
      if (deposit2) dep2_w++;
      if (!deposit2 && prev_dep2 && dep2_w != H2) dep2_bad++;
      if (load_pc2 && !prev_lp2) begin lp2_val.push_back(sw2[11:0]); lp2_addr.push_back(img_addr2); end
      if (load_pc2 && deposit2) dep2_bad++;
      prev_dep2 = deposit2; prev_lp2 = load_pc2;
    end
  end

  task automatic clear_mon();
    mon_en = 1'b0;
    lp_val.delete(); dep_val.delete(); dep_addr.delete(); lp_wid.delete(); dep_wid.delete();
    dly_log.delete();
    overlap = 0; addr_moves = 0; req_rises = 0; done_cnt = 0;
    prev_lp = 1'b0; prev_dep = 1'b0; prev_req = 1'b0; prev_addr = '0;
  endtask

  // Cycles from start acceptance until the run switch rises
  function automatic int model_time(int hold, int n);
    int t;
    t = 6 * hold;
    for (int i = 0; i < n && i < dly_log.size(); i++) t += dly_log[i] + 1 + 3 * hold;
    return t;
  endfunction

  task automatic do_sequence(input int n, input logic [11:0] pc, input bit inject,
                             output int t_run, output logic busy0);
    int inj_k;
    clear_mon();
    mon_en = 1'b1;
    word_count = 13'(n); start_pc = pc; start = 1'b1;
    @(negedge clk);
    start = 1'b0; busy0 = busy;
    word_count = 13'($urandom); start_pc = 12'($urandom);
    t_run = 0; inj_k = 0;
    while (sw[12] !== 1'b1 && t_run < 3000) begin
      if (inject && img_req === 1'b1) begin
        inj_k++;
        if (inj_k == 10) begin word_count = 13'd5; start_pc = ~pc; start = 1'b1; end
      end
      @(negedge clk);
      start = 1'b0;
      t_run++;
    end
    if (sw[12] !== 1'b1) t_run = -1;
    repeat (H + 3) @(negedge clk);
  endtask

  task automatic halt_run(input int hi, output logic d1, output logic s12, output logic b1,
                          output logic d2, output logic b2);
    run_led = 1'b1;
    repeat (hi) @(negedge clk);
    run_led = 1'b0;
    @(negedge clk);
    d1 = done; s12 = sw[12]; b1 = busy;
    @(negedge clk);
    d2 = done; b2 = busy;
  endtask

  task automatic test_reset();
    btnCpuReset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({sw, load_pc, deposit, img_req, img_addr, busy, done} !== '0)
      $display("FAIL reset_outputs: got %h want 0", {sw, load_pc, deposit, img_req, img_addr, busy, done});
    else passed++;
    total++;
    if ({sw2, load_pc2, deposit2, img_req2, img_addr2, busy2, done2} !== '0)
      $display("FAIL reset_outputs2: got %h want 0", {sw2, load_pc2, deposit2, img_req2, img_addr2, busy2, done2});
    else passed++;
    btnCpuReset = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if ({busy, img_req, load_pc, deposit, sw} !== '0)
      $display("FAIL idle_after_reset: got %h want 0", {busy, img_req, load_pc, deposit, sw});
    else passed++;
  endtask

  task automatic test_basic();
    int t, bad;
    logic b0, d1, s12, b1, d2, b2;
    mem[0] = 12'o7300; mem[1] = 12'o1234; mem[2] = 12'o7402;
    fixed_dly = 0;
    do_sequence(3, 12'o0200, 1'b0, t, b0);
    total++; if (b0 !== 1'b1) $display("FAIL basic_busy: got %b want 1", b0); else passed++;
    total++; if (t != model_time(H, 3)) $display("FAIL basic_time: got %0d want %0d", t, model_time(H, 3)); else passed++;
    bad = (dep_val.size() != 3) ? 1 : 0;
    for (int i = 0; i < 3 && i < dep_val.size() && i < dep_wid.size(); i++)
      if (dep_val[i] !== mem[i] || dep_addr[i] !== 12'(i) || dep_wid[i] != H) bad++;
    total++; if (bad != 0) $display("FAIL basic_deposits: got %0d pulses %0d bad want 3 pulses 0 bad", dep_val.size(), bad); else passed++;
    bad = (lp_val.size() != 2 || lp_wid.size() != 2) ? 1 : 0;
    if (bad == 0) bad = (lp_val[0] !== 12'o0 || lp_val[1] !== 12'o0200 || lp_wid[0] != H || lp_wid[1] != H) ? 1 : 0;
    total++; if (bad != 0) $display("FAIL basic_load_pc: got %0d pulses want 2 (values 0, 0200 octal, width %0d)", lp_val.size(), H); else passed++;
    total++; if (img_addr !== 12'd3) $display("FAIL basic_addr_end: got %0d want 3", img_addr); else passed++;
    total++; if (req_rises != 3 || overlap != 0) $display("FAIL basic_req_overlap: got req %0d overlap %0d want 3 0", req_rises, overlap); else passed++;
    halt_run(50, d1, s12, b1, d2, b2);
    total++; if ({d1, s12, b1} !== 3'b101) $display("FAIL basic_done: got done/sw12/busy %b want 101", {d1, s12, b1}); else passed++;
    total++; if ({d2, b2, done_cnt == 1} !== 3'b001) $display("FAIL basic_after_done: got done/busy %b%b pulses %0d want 00 1", d2, b2, done_cnt); else passed++;
  endtask

  task automatic test_zero_words();
    int t;
    logic b0, d1, s12, b1, d2, b2;
    fixed_dly = 0;
    run_led = 1'b0;
    do_sequence(0, 12'o0200, 1'b0, t, b0);
    total++; if (req_rises != 0 || dep_val.size() != 0) $display("FAIL zero_no_fetch: got req %0d dep %0d want 0 0", req_rises, dep_val.size()); else passed++;
    total++;
    if (lp_val.size() != 2 || (lp_val.size() == 2 && (lp_val[0] !== 12'o0 || lp_val[1] !== 12'o0200)))
      $display("FAIL zero_load_pc: got %0d pulses want 2 (0, 0200 octal)", lp_val.size());
    else passed++;
    total++; if (t != 6 * H) $display("FAIL zero_time: got %0d want %0d", t, 6 * H); else passed++;
    repeat (30) @(negedge clk);
    total++;
    if (done_cnt != 0 || busy !== 1'b1 || sw[12] !== 1'b1)
      $display("FAIL low_led_no_halt: got done %0d busy %b sw12 %b want 0 1 1", done_cnt, busy, sw[12]);
    else passed++;
    halt_run(5, d1, s12, b1, d2, b2);
    total++; if ({d1, s12, d2, b2} !== 4'b1000) $display("FAIL zero_done: got %b want 1000", {d1, s12, d2, b2}); else passed++;
  endtask

  task automatic test_random();
    int t, n, bad;
    logic [11:0] pc;
    logic b0, d1, s12, b1, d2, b2;
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(1, 6);
      pc = 12'($urandom);
      for (int i = 0; i < n; i++) mem[i] = 12'($urandom);
      fixed_dly = -1;
      do_sequence(n, pc, 1'b0, t, b0);
      total++; if (t != model_time(H, n)) $display("FAIL rand_time[%0d]: got %0d want %0d", it, t, model_time(H, n)); else passed++;
      bad = (dep_val.size() != n) ? 1 : 0;
      for (int i = 0; i < n && i < dep_val.size() && i < dep_wid.size(); i++)
        if (dep_val[i] !== mem[i] || dep_addr[i] !== 12'(i) || dep_wid[i] != H) bad++;
      total++; if (bad != 0) $display("FAIL rand_deposits[%0d]: got %0d pulses %0d bad want %0d pulses 0 bad", it, dep_val.size(), bad, n); else passed++;
      total++;
      if (lp_val.size() != 2 || (lp_val.size() == 2 && (lp_val[0] !== 12'd0 || lp_val[1] !== pc)))
        $display("FAIL rand_load_pc[%0d]: got %0d pulses want 2 (0, %o)", it, lp_val.size(), pc);
      else passed++;
      total++;
      if (img_addr !== 12'(n) || overlap != 0 || addr_moves != 0)
        $display("FAIL rand_addr[%0d]: got addr %0d overlap %0d moves %0d want %0d 0 0", it, img_addr, overlap, addr_moves, n);
      else passed++;
      halt_run($urandom_range(2, 20), d1, s12, b1, d2, b2);
      total++; if ({d1, s12, b1, d2, b2} !== 5'b10100) $display("FAIL rand_done[%0d]: got %b want 10100", it, {d1, s12, b1, d2, b2}); else passed++;
    end
  endtask

  task automatic test_fetch_stall();
    int t, bad;
    logic b0, d1, s12, b1, d2, b2;
    mem[0] = 12'($urandom); mem[1] = 12'($urandom);
    fixed_dly = 37;
    do_sequence(2, 12'o3456, 1'b1, t, b0);
    total++; if (addr_moves != 0 || req_rises != 2) $display("FAIL stall_req_stable: got moves %0d req %0d want 0 2", addr_moves, req_rises); else passed++;
    bad = (dep_val.size() != 2) ? 1 : 0;
    for (int i = 0; i < 2 && i < dep_val.size(); i++) if (dep_val[i] !== mem[i]) bad++;
    total++; if (bad != 0) $display("FAIL stall_capture: got %0d pulses %0d bad want 2 0", dep_val.size(), bad); else passed++;
    total++;
    if (lp_val.size() != 2 || (lp_val.size() == 2 && lp_val[1] !== 12'o3456))
      $display("FAIL stall_start_ignored: got %0d pulses want 2 ending 3456 octal", lp_val.size());
    else passed++;
    total++; if (t != model_time(H, 2)) $display("FAIL stall_time: got %0d want %0d", t, model_time(H, 2)); else passed++;
    halt_run(4, d1, s12, b1, d2, b2);
    total++; if ({d1, d2, b2} !== 3'b100) $display("FAIL stall_done: got %b want 100", {d1, d2, b2}); else passed++;
  endtask

  task automatic test_reset_mid();
    int t, k, bad;
    logic b0, d1, s12, b1, d2, b2;
    for (int i = 0; i < 3; i++) mem[i] = 12'($urandom) | 12'd1;
    fixed_dly = 2;
    clear_mon();
    mon_en = 1'b1;
    word_count = 13'd3; start_pc = 12'o0777; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(deposit === 1'b1 && img_addr === 12'd1) && k < 1000) begin @(negedge clk); k++; end
    total++; if (k >= 1000) $display("FAIL reach_dep_hi: got timeout want deposit of word 1"); else passed++;
    repeat (3) @(negedge clk);
    #2 btnCpuReset = 1'b0;
    #1;
    total++;
    if ({deposit, sw, busy, img_addr, load_pc, img_req} !== '0)
      $display("FAIL async_abort: got %h want 0", {deposit, sw, busy, img_addr, load_pc, img_req});
    else passed++;
    @(negedge clk);
    btnCpuReset = 1'b1;
    repeat (20) @(negedge clk);
    total++; if ({busy, img_req, load_pc, deposit, sw[12]} !== '0) $display("FAIL stays_idle: got %b want 0", {busy, img_req, load_pc, deposit, sw[12]}); else passed++;
    do_sequence(2, 12'o0400, 1'b0, t, b0);
    bad = (dep_val.size() != 2 || lp_val.size() != 2) ? 1 : 0;
    for (int i = 0; i < 2 && i < dep_val.size(); i++) if (dep_val[i] !== mem[i] || dep_addr[i] !== 12'(i)) bad++;
    if (lp_val.size() == 2 && (lp_val[0] !== 12'd0 || lp_val[1] !== 12'o0400)) bad++;
    total++; if (bad != 0) $display("FAIL restart_sequence: got %0d bad want 0", bad); else passed++;
    total++; if (t != model_time(H, 2)) $display("FAIL restart_time: got %0d want %0d", t, model_time(H, 2)); else passed++;
    halt_run(3, d1, s12, b1, d2, b2);
    total++; if ({d1, d2, b2} !== 3'b100) $display("FAIL restart_done: got %b want 100", {d1, d2, b2}); else passed++;
  endtask

  task automatic test_wrap(input logic [12:0] wc, input string tag);
    int t;
    bit ok;
    mon2_en = 1'b0;
    lp2_val.delete(); lp2_addr.delete();
    dep2_cnt = 0; dep2_bad = 0; prev_dep2 = 1'b0; prev_lp2 = 1'b0;
    mon2_en = 1'b1;
    word_count2 = wc; start_pc2 = 12'o4321; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0; word_count2 = '0;
    t = 0;
    while (sw2[12] !== 1'b1 && t < 30000) begin @(negedge clk); t++; end
    total++; if (t != 6 * H2 + 4096 * (1 + 3 * H2)) $display("FAIL %s_time: got %0d want %0d", tag, t, 6 * H2 + 4096 * (1 + 3 * H2)); else passed++;
    total++; if (dep2_cnt != 4096 || dep2_bad != 0) $display("FAIL %s_deposits: got %0d pulses %0d bad want 4096 0", tag, dep2_cnt, dep2_bad); else passed++;
    ok = (lp2_val.size() == 2) ? (lp2_val[1] === 12'o4321 && lp2_addr[1] === 12'd0) : 1'b0;
    total++; if (!ok || img_addr2 !== 12'd0) $display("FAIL %s_wrap_pc: got %0d pulses addr %0d want 2 pulses addr 0", tag, lp2_val.size(), img_addr2); else passed++;
    repeat (H2 + 3) @(negedge clk);
    run_led2 = 1'b1;
    repeat (3) @(negedge clk);
    run_led2 = 1'b0;
    @(negedge clk);
    total++; if ({done2, sw2[12]} !== 2'b10) $display("FAIL %s_done: got %b want 10", tag, {done2, sw2[12]}); else passed++;
    @(negedge clk);
    total++; if ({done2, busy2} !== 2'b00) $display("FAIL %s_idle: got %b want 00", tag, {done2, busy2}); else passed++;
    mon2_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_words();
    test_random();
    test_fetch_stall();
    test_reset_mid();
    test_wrap(13'd4096, "wrap4096");
    test_wrap(13'h1FFF, "clamp");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
